// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns, converter state type and helpers for the 7-segment scan driver
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter, one bit per cycle
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int BIN_W  = 7
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BIN_W-1:0]      bin,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [63:0] OVF_LIM = pow10(DIGITS);

    conv_state_t        state, state_nx;
    logic [BIN_W-1:0]   sh;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_next;

    always_comb begin
        acc_adj = acc;
        for (int j = 0; j < DIGITS; j++) begin
            if (acc[j*4 +: 4] >= 4'd5) acc_adj[j*4 +: 4] = acc[j*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load) state_nx = SHIFT;
            SHIFT:   if (cnt == CNT_W'(BIN_W - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_next <= 1'b0;
        end else if (state == IDLE && load) begin
            sh       <= bin;
            acc      <= '0;
            cnt      <= '0;
            ovf_next <= 64'(bin) >= OVF_LIM;
        end else if (state == SHIFT) begin
            // BCD digits beyond DIGITS are dropped; such values are flagged by ovf_next and blanked
            {acc, sh} <= {acc_adj[BCD_W-2:0], sh, 1'b0};
            cnt       <= cnt + 1'b1;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign bcd  = acc;
    assign ovf  = ovf_next;

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment driver with BCD conversion; SEG7_LZB_EN enables leading-zero blanking
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int BIN_W    = 7,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BIN_W-1:0]  bin,
    input  logic              load,
    output logic              busy,
    output logic              ovf,
    output logic [6:0]        seg_n,
    output logic [DIGITS-1:0] an_n
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);

    logic                  conv_done;
    logic                  conv_ovf;
    logic [4*DIGITS-1:0]   conv_bcd;

    logic [4*DIGITS-1:0]   disp_bcd;
    logic                  disp_ovf;
    logic                  disp_valid;

    logic [SCAN_W-1:0]     scan_cnt;
    logic [IDX_W-1:0]      idx;

    logic [3:0]            nib;
    logic [6:0]            seg_nx;
    logic [DIGITS-1:0]     an_nx;

    bin2bcd_seq #(
        .DIGITS (DIGITS),
        .BIN_W  (BIN_W)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .bin   (bin),
        .load  (load),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_bcd   <= '0;
            disp_ovf   <= 1'b0;
            disp_valid <= 1'b0;
        end else if (conv_done) begin
            disp_bcd   <= conv_bcd;
            disp_ovf   <= conv_ovf;
            disp_valid <= 1'b1;
        end
    end

    // Free-running scan; conversions never touch the phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

`ifdef SEG7_LZB_EN
    logic upper_nz;
`endif

    always_comb begin
        nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (int'(idx) == i) nib = disp_bcd[i*4 +: 4];
        end
        seg_nx = SEG_BLANK;
        if (disp_valid && !disp_ovf) seg_nx = seg_of(nib);
`ifdef SEG7_LZB_EN
        upper_nz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (i >= int'(idx) && disp_bcd[i*4 +: 4] != 4'd0) upper_nz = 1'b1;
        end
        if (!upper_nz && idx != '0) seg_nx = SEG_BLANK;
`endif
        an_nx = disp_valid ? ~(DIGITS'(1) << idx) : '1;
    end

    // Registered outputs give the display its single atomic update edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= SEG_BLANK;
            an_n  <= '1;
            ovf   <= 1'b0;
        end else begin
            seg_n <= seg_nx;
            an_n  <= an_nx;
            ovf   <= disp_ovf;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed self-checking bench for seg7_scan_driver (2-digit and 4-digit builds)
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  bin_a;
    logic        load_a;
    logic        busy_a, ovf_a;
    logic [6:0]  seg_a;
    logic [1:0]  an_a;
    logic [13:0] bin_b;
    logic        load_b;
    logic        busy_b, ovf_b;
    logic [6:0]  seg_b;
    logic [3:0]  an_b;

    int errors = 0;
    int checks = 0;

`ifdef SEG7_LZB_EN
    localparam logic [6:0] LZ_EXP = 7'b1111111;
`else
    localparam logic [6:0] LZ_EXP = 7'b0000001;
`endif

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIGITS(2), .BIN_W(7), .SCAN_DIV(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bin(bin_a), .load(load_a),
        .busy(busy_a), .ovf(ovf_a), .seg_n(seg_a), .an_n(an_a)
    );

    seg7_scan_driver #(.DIGITS(4), .BIN_W(14), .SCAN_DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bin(bin_b), .load(load_b),
        .busy(busy_b), .ovf(ovf_b), .seg_n(seg_b), .an_n(an_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input bit sel, input int v);
        @(negedge clk);
        if (sel) begin bin_b = 14'(v); load_b = 1'b1; end
        else     begin bin_a = 7'(v);  load_a = 1'b1; end
        @(negedge clk);
        load_a = 1'b0;
        load_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel);
        int n;
        n = 0;
        while ((sel ? busy_b : busy_a) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("conv_timeout", 32'(n < 100), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic get_digit(input bit sel, input int d, output logic [6:0] s);
        logic [3:0] an, want;
        bit found;
        want = ~(4'b0001 << d);
        if (!sel) want[3:2] = 2'b11;
        s = 7'h7F;
        found = 1'b0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(negedge clk);
            an = sel ? an_b : {2'b11, an_a};
            if (an == want) begin
                s = sel ? seg_b : seg_a;
                found = 1'b1;
            end
        end
        check("digit_timeout", 32'(found), 32'd1);
    endtask

    logic [6:0] s;
    logic [1:0] prev, inv;
    int len, bcnt;

    initial begin
        rst_n = 1'b0; load_a = 1'b0; load_b = 1'b0; bin_a = '0; bin_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_ovf", 32'(ovf_a), 32'd0);
        check("rst_seg", 32'(seg_a), 32'h7F);
        check("rst_an_a", 32'(an_a), 32'h3);
        check("rst_an_b", 32'(an_b), 32'hF);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("an_pre_conv", 32'(an_a), 32'h3);

        // 69: busy for 8 cycles, display appears at edge 9 after the load edge
        do_load(1'b0, 69);
        bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy_a) bcnt++;
            if (i == 8) check("an_before_edge9", 32'(an_a), 32'h3);
            if (i == 9) check("an_at_edge9", 32'(an_a != 2'b11), 32'd1);
            if (i == 9) check("ovf_69", 32'(ovf_a), 32'd0);
            @(negedge clk);
        end
        check("busy_cycles", 32'(bcnt), 32'd8);
        get_digit(1'b0, 0, s); check("d0_69", 32'(s), 32'b0000100);
        get_digit(1'b0, 1, s); check("d1_69", 32'(s), 32'b0100000);

        // Scan phase: each enable lasts 4 cycles and alternates
        prev = an_a; len = 0;
        while (an_a == prev && len < 20) begin @(negedge clk); len++; end
        for (int r = 0; r < 3; r++) begin
            prev = an_a; len = 0;
            while (an_a == prev && len < 20) begin @(negedge clk); len++; end
            inv = ~prev;
            check("scan_len", 32'(len), 32'd4);
            check("scan_alt", 32'(an_a), 32'(inv));
        end

        // Second load during busy is dropped
        do_load(1'b0, 42);
        @(negedge clk);
        do_load(1'b0, 13);
        wait_done(1'b0);
        get_digit(1'b0, 0, s); check("d0_42", 32'(s), 32'b0010010);
        get_digit(1'b0, 1, s); check("d1_42", 32'(s), 32'b1001100);

        do_load(1'b0, 100);
        wait_done(1'b0);
        check("ovf_100", 32'(ovf_a), 32'd1);
        get_digit(1'b0, 0, s); check("d0_100", 32'(s), 32'h7F);
        get_digit(1'b0, 1, s); check("d1_100", 32'(s), 32'h7F);

        do_load(1'b0, 5);
        wait_done(1'b0);
        check("ovf_5", 32'(ovf_a), 32'd0);
        get_digit(1'b0, 0, s); check("d0_5", 32'(s), 32'b0100100);
        get_digit(1'b0, 1, s); check("d1_5", 32'(s), 32'(LZ_EXP));

        do_load(1'b0, 0);
        wait_done(1'b0);
        get_digit(1'b0, 0, s); check("d0_0", 32'(s), 32'b0000001);
        get_digit(1'b0, 1, s); check("d1_0", 32'(s), 32'(LZ_EXP));

        do_load(1'b0, 127);
        wait_done(1'b0);
        check("ovf_127", 32'(ovf_a), 32'd1);

        do_load(1'b0, 70);
        wait_done(1'b0);
        check("ovf_70", 32'(ovf_a), 32'd0);
        get_digit(1'b0, 0, s); check("d0_70", 32'(s), 32'b0000001);
        get_digit(1'b0, 1, s); check("d1_70", 32'(s), 32'b0001111);

        // 4-digit build
        do_load(1'b1, 9999);
        wait_done(1'b1);
        check("ovf_9999", 32'(ovf_b), 32'd0);
        for (int d = 0; d < 4; d++) begin
            get_digit(1'b1, d, s);
            check("b_digit_9999", 32'(s), 32'b0000100);
        end
        do_load(1'b1, 10000);
        wait_done(1'b1);
        check("ovf_10000", 32'(ovf_b), 32'd1);
        get_digit(1'b1, 2, s); check("b_d2_10000", 32'(s), 32'h7F);

        // Reset in the third SHIFT cycle aborts and clears everything at once
        do_load(1'b0, 69);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_seg", 32'(seg_a), 32'h7F);
        check("mid_rst_an", 32'(an_a), 32'h3);
        check("mid_rst_ovf_b", 32'(ovf_b), 32'd0);
        check("mid_rst_an_b", 32'(an_b), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("post_rst_busy", 32'(busy_a), 32'd0);
        check("post_rst_an", 32'(an_a), 32'h3);
        check("post_rst_seg", 32'(seg_a), 32'h7F);
        do_load(1'b0, 9);
        wait_done(1'b0);
        get_digit(1'b0, 0, s); check("d0_9", 32'(s), 32'b0000100);
        get_digit(1'b0, 1, s); check("d1_9", 32'(s), 32'(LZ_EXP));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
